// File: rtl/tank_gfx_pkg.sv
// rtl/tank_gfx_pkg.sv - shared types and geometry for the tank sprite layers
package tank_gfx_pkg;
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam int SPR_SIZE     = 32;
  localparam int SPR_BITS     = $clog2(SPR_SIZE);
  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam logic [3:0] TRANSP_IDX = 4'd0;
  localparam int FLASH_FRAMES = 16;
  localparam int FLASH_W      = $clog2(FLASH_FRAMES + 1);
endpackage

// File: rtl/tank_sprite_addr_gen.sv
// rtl/tank_sprite_addr_gen.sv - bounding-box test and rotated sprite ROM address
module tank_sprite_addr_gen
  import tank_gfx_pkg::*;
(
  input  logic [9:0]            draw_x,
  input  logic [9:0]            draw_y,
  input  logic [9:0]            x_lat,
  input  logic [9:0]            y_lat,
  input  dir_t                  dir,
  output logic                  in_box,
  output logic [2*SPR_BITS-1:0] rom_address
);
  localparam logic [SPR_BITS-1:0] N_MAX = SPR_BITS'(SPR_SIZE - 1);

  logic [10:0]         dx, dy, xl, yl;
  logic                in_x, in_y, on_screen;
  logic [SPR_BITS-1:0] lx, ly, r, c;

  always_comb begin
    // 11-bit compare so a box straddling the right/bottom edge never wraps to 0
    dx        = {1'b0, draw_x};
    dy        = {1'b0, draw_y};
    xl        = {1'b0, x_lat};
    yl        = {1'b0, y_lat};
    in_x      = (dx >= xl) && (dx < xl + 11'(SPR_SIZE));
    in_y      = (dy >= yl) && (dy < yl + 11'(SPR_SIZE));
    on_screen = (x_lat < 10'(H_RES)) && (y_lat < 10'(V_RES));
    in_box    = in_x && in_y && on_screen;
    lx        = draw_x[SPR_BITS-1:0] - x_lat[SPR_BITS-1:0];
    ly        = draw_y[SPR_BITS-1:0] - y_lat[SPR_BITS-1:0];
    r         = ly;
    c         = lx;
    case (dir)
      DIR_UP:    begin r = ly;          c = lx;          end
      DIR_RIGHT: begin r = N_MAX - lx;  c = ly;          end
      DIR_DOWN:  begin r = N_MAX - ly;  c = N_MAX - lx;  end
      DIR_LEFT:  begin r = lx;          c = N_MAX - ly;  end
    endcase
    rom_address = in_box ? {r, c} : '0;
  end
endmodule

// File: rtl/tank_sprite_layer.sv
// rtl/tank_sprite_layer.sv - one tank sprite: frame-latched position, hit flash,
// and a 2-stage pipeline aligned to the external sprite ROM's read latency
module tank_sprite_layer
  import tank_gfx_pkg::*;
(
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       frame_start,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [1:0] tank_dir,
  input  logic       tank_alive,
  input  logic       hit_pulse,
  output logic [9:0] rom_address,
  input  logic [3:0] rom_q,
  output logic [3:0] pix_idx,
  output logic       pix_hit
);
  logic [9:0]         x_lat_q, x_lat_d, y_lat_q, y_lat_d;
  dir_t               dir_lat_q, dir_lat_d;
  logic               alive_lat_q, alive_lat_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               in_box_q, in_box_d, blank_q, blank_d;
  logic               alive_q, alive_d, vis_q, vis_d;
  logic [3:0]         pix_idx_q, pix_idx_d;
  logic               pix_hit_q, pix_hit_d;
  logic               in_box;

  tank_sprite_addr_gen u_addr_gen (
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .x_lat       (x_lat_q),
    .y_lat       (y_lat_q),
    .dir         (dir_lat_q),
    .in_box      (in_box),
    .rom_address (rom_address)
  );

  always_comb begin
    x_lat_d     = x_lat_q;
    y_lat_d     = y_lat_q;
    dir_lat_d   = dir_lat_q;
    alive_lat_d = alive_lat_q;
    flash_cnt_d = flash_cnt_q;
    // Position only moves at frame boundaries so a frame is never torn
    if (frame_start) begin
      x_lat_d     = tank_x;
      y_lat_d     = tank_y;
      dir_lat_d   = dir_t'(tank_dir);
      alive_lat_d = tank_alive;
    end
    if (hit_pulse)
      flash_cnt_d = FLASH_W'(FLASH_FRAMES);
    else if (frame_start && flash_cnt_q != '0)
      flash_cnt_d = flash_cnt_q - 1'b1;

    in_box_d  = in_box;
    blank_d   = blank;
    alive_d   = alive_lat_q;
    vis_d     = (flash_cnt_q == '0) || !flash_cnt_q[1];

    pix_hit_d = in_box_q && blank_q && alive_q && vis_q && (rom_q != TRANSP_IDX);
    pix_idx_d = pix_hit_d ? rom_q : 4'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      x_lat_q     <= '0;
      y_lat_q     <= '0;
      dir_lat_q   <= DIR_UP;
      alive_lat_q <= 1'b0;
      flash_cnt_q <= '0;
      in_box_q    <= 1'b0;
      blank_q     <= 1'b0;
      alive_q     <= 1'b0;
      vis_q       <= 1'b0;
      pix_idx_q   <= '0;
      pix_hit_q   <= 1'b0;
    end else begin
      x_lat_q     <= x_lat_d;
      y_lat_q     <= y_lat_d;
      dir_lat_q   <= dir_lat_d;
      alive_lat_q <= alive_lat_d;
      flash_cnt_q <= flash_cnt_d;
      in_box_q    <= in_box_d;
      blank_q     <= blank_d;
      alive_q     <= alive_d;
      vis_q       <= vis_d;
      pix_idx_q   <= pix_idx_d;
      pix_hit_q   <= pix_hit_d;
    end
  end

  assign pix_idx = pix_idx_q;
  assign pix_hit = pix_hit_q;
endmodule
